// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
// Packet layout and default sizing live here.
package inst_fetch_queue_pkg;

    localparam int FETCH_WIDTH = 4;
    localparam int IFQ_DEPTH   = 8;
    localparam int IFQ_SKID    = 2;

    typedef struct packed {
        logic [31:0]                  pc;
        logic [FETCH_WIDTH-1:0][31:0] inst;
        logic [FETCH_WIDTH-1:0]       mask;
        logic                         predict;
        logic [31:0]                  target;
    } fetch_pkt_t;

endpackage

// File: rtl/ifq_ptr_ctrl.sv
// Pointer, occupancy and status control for the fetch queue.
// Flush clears pointers and count but leaves the sticky overflow flag.
module ifq_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int SKID  = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic             push_nz,
    input  logic             pop_ready,
    output logic             push_en,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [CNT_W-1:0] count,
    output logic             out_valid,
    output logic             full_ififo,
    output logic             ovf_err
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(DEPTH - SKID);

    logic pop_fire;
    logic push_ok;
    logic is_full;

    assign out_valid  = (count != '0);
    assign full_ififo = (count >= THRESH_C);
    assign is_full    = (count == DEPTH_C);
    assign pop_fire   = out_valid & pop_ready;
    assign push_ok    = push_valid & push_nz & ~flush;
    // a full queue still takes a packet into the slot freed by a pop
    assign push_en    = push_ok & (~is_full | pop_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_err <= 1'b0;
        else if (push_ok & is_full & ~pop_fire)
            ovf_err <= 1'b1;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// First-word fall-through: head entry drives the outputs directly.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int SKID  = IFQ_SKID,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_valid,
    input  logic [31:0]                  push_pc,
    input  logic [FETCH_WIDTH-1:0][31:0] push_inst,
    input  logic [FETCH_WIDTH-1:0]       push_mask,
    input  logic                         push_predict,
    input  logic [31:0]                  push_target,
    output logic                         full_ififo,
    input  logic                         pop_ready,
    output logic                         out_valid,
    output logic [FETCH_WIDTH-1:0][31:0] out_pc,
    output logic [FETCH_WIDTH-1:0][31:0] out_inst,
    output logic [FETCH_WIDTH-1:0]       out_mask,
    output logic                         out_predict,
    output logic [31:0]                  out_target,
    output logic [CNT_W-1:0]             count,
    output logic                         ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             push_en;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    fetch_pkt_t       wr_pkt;
    fetch_pkt_t       head;
    fetch_pkt_t       mem [DEPTH];

    ifq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .SKID  (SKID),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_nz    (|push_mask),
        .pop_ready  (pop_ready),
        .push_en    (push_en),
        .rd_ptr     (rd_ptr),
        .wr_ptr     (wr_ptr),
        .count      (count),
        .out_valid  (out_valid),
        .full_ififo (full_ififo),
        .ovf_err    (ovf_err)
    );

    assign wr_pkt = '{
        pc:      push_pc,
        inst:    push_inst,
        mask:    push_mask,
        predict: push_predict,
        target:  push_target
    };

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_ptr] <= wr_pkt;
    end

    assign head        = mem[rd_ptr];
    assign out_inst    = head.inst;
    assign out_mask    = head.mask;
    assign out_predict = head.predict;
    assign out_target  = head.target;

    // only slot 0 PC is stored; the rest are sequential words
    always_comb begin
        out_pc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            out_pc[i] = head.pc + 32'(4 * i);
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue.
// Table vectors plus wrap and flush sequences.
module tb_inst_fetch_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             push_valid;
    logic [31:0]      push_pc;
    logic [3:0][31:0] push_inst;
    logic [3:0]       push_mask;
    logic             push_predict;
    logic [31:0]      push_target;
    logic             full_ififo;
    logic             pop_ready;
    logic             out_valid;
    logic [3:0][31:0] out_pc;
    logic [3:0][31:0] out_inst;
    logic [3:0]       out_mask;
    logic             out_predict;
    logic [31:0]      out_target;
    logic [3:0]       count;
    logic             ovf_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push_valid   (push_valid),
        .push_pc      (push_pc),
        .push_inst    (push_inst),
        .push_mask    (push_mask),
        .push_predict (push_predict),
        .push_target  (push_target),
        .full_ififo   (full_ififo),
        .pop_ready    (pop_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_mask     (out_mask),
        .out_predict  (out_predict),
        .out_target   (out_target),
        .count        (count),
        .ovf_err      (ovf_err)
    );

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic [3:0]  mask;
        logic        pop;
        logic        fl;
        logic        ev;
        int          ecnt;
        logic        efull;
        logic        eovf;
        logic [31:0] epc;
        logic [3:0]  emask;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] inst_of(logic [31:0] pc, int i);
        return (pc << 4) ^ (32'h1111_1111 * 32'(i + 1));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_head(string tag, logic [31:0] epc, logic [3:0] em);
        for (int i = 0; i < 4; i++) begin
            chk({tag, " pc"}, out_pc[i], epc + 32'(4 * i));
            chk({tag, " inst"}, out_inst[i], inst_of(epc, i));
        end
        chk({tag, " mask"}, 32'(out_mask), 32'(em));
        chk({tag, " pred"}, 32'(out_predict), 32'(em != 4'hF));
        chk({tag, " tgt"}, out_target, epc + 32'h40);
    endtask

    task automatic chk_stat(string tag, logic ev, int c, logic f, logic o);
        chk({tag, " valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " count"}, 32'(count), 32'(c));
        chk({tag, " full"}, 32'(full_ififo), 32'(f));
        chk({tag, " ovf"}, 32'(ovf_err), 32'(o));
    endtask

    task automatic drive(logic pv, logic [31:0] pc, logic [3:0] m,
                         logic pop, logic fl);
        @(negedge clk);
        push_valid   = pv;
        push_pc      = pc;
        push_mask    = m;
        push_predict = (m != 4'hF);
        push_target  = pc + 32'h40;
        for (int i = 0; i < 4; i++)
            push_inst[i] = inst_of(pc, i);
        pop_ready = pop;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
    endtask

    task automatic add(logic pv, logic [31:0] pc, logic [3:0] m,
                       logic pop, logic ev, int c, logic f, logic o,
                       logic [31:0] epc, logic [3:0] em);
        vec_t v;
        v = '{pv, pc, m, pop, 1'b0, ev, c, f, o, epc, em};
        vt.push_back(v);
    endtask

    logic [31:0] mq_pc[$];
    logic [3:0]  mq_m[$];

    initial begin
        logic [31:0] b;
        b = 32'h1C00_1000;
        add(1, 32'h1C00_0000, 4'hF, 0, 1, 1, 0, 0, 32'h1C00_0000, 4'hF);
        add(0, 32'h0, 4'hF, 1, 0, 0, 0, 0, 32'h0, 4'h0);
        add(1, 32'h1C00_0040, 4'h0, 0, 0, 0, 0, 0, 32'h0, 4'h0);
        add(1, 32'h1C00_00C0, 4'h3, 0, 1, 1, 0, 0, 32'h1C00_00C0, 4'h3);
        add(0, 32'h0, 4'hF, 1, 0, 0, 0, 0, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++)
            add(1, b + 32'(16 * k), 4'hF, 0, 1, k + 1, (k >= 5), 0, b, 4'hF);
        add(1, b + 32'h80, 4'hF, 0, 1, 8, 1, 1, b, 4'hF);
        add(1, b + 32'h90, 4'hF, 1, 1, 8, 1, 1, b + 32'h10, 4'hF);
        for (int i = 1; i <= 7; i++)
            add(0, 32'h0, 4'hF, 1, 1, 8 - i, (8 - i) >= 6, 1,
                (i <= 6) ? b + 32'(16 + 16 * i) : b + 32'h90, 4'hF);
        add(0, 32'h0, 4'hF, 1, 0, 0, 0, 1, 32'h0, 4'h0);

        push_pc = '0;
        push_inst = '0;
        push_mask = '0;
        push_predict = 1'b0;
        push_target = '0;
        do_reset();
        chk_stat("reset", 0, 0, 0, 0);

        foreach (vt[n]) begin
            drive(vt[n].pv, vt[n].pc, vt[n].mask, vt[n].pop, vt[n].fl);
            chk_stat($sformatf("vec%0d", n), vt[n].ev, vt[n].ecnt,
                     vt[n].efull, vt[n].eovf);
            if (vt[n].ev)
                chk_head($sformatf("vec%0d", n), vt[n].epc, vt[n].emask);
        end

        // wrap: 10 pushes interleaved with pops, reference queue
        do_reset();
        for (int k = 0; k < 30; k++) begin
            logic pv, pop, fire;
            logic [31:0] pc;
            logic [3:0] m;
            pv = (k < 15) && (k % 3 != 2);
            pop = (k % 2 == 1) || (k >= 15);
            pc = 32'h1C00_2000 + 32'(32 * k);
            m = (k % 4 == 1) ? 4'b0111 : 4'hF;
            fire = pop && (mq_pc.size() != 0);
            if (fire) begin
                void'(mq_pc.pop_front());
                void'(mq_m.pop_front());
            end
            if (pv && (mq_pc.size() < 8)) begin
                mq_pc.push_back(pc);
                mq_m.push_back(m);
            end
            drive(pv, pc, m, pop, 0);
            chk($sformatf("wrap%0d count", k), 32'(count), 32'(mq_pc.size()));
            chk($sformatf("wrap%0d valid", k), 32'(out_valid),
                32'(mq_pc.size() != 0));
            if (mq_pc.size() != 0)
                chk_head($sformatf("wrap%0d", k), mq_pc[0], mq_m[0]);
        end

        // flush with same-cycle push and pop at count 5
        do_reset();
        for (int k = 0; k < 5; k++)
            drive(1, 32'h1C00_3000 + 32'(16 * k), 4'hF, 0, 0);
        chk_stat("pre_flush", 1, 5, 0, 0);
        drive(1, 32'h1C00_3F00, 4'hF, 1, 1);
        chk_stat("flush", 0, 0, 0, 0);
        drive(0, 32'h0, 4'hF, 0, 0);
        chk_stat("post_flush", 0, 0, 0, 0);
        drive(1, 32'h1C00_4000, 4'b0001, 0, 0);
        chk_stat("after_flush", 1, 1, 0, 0);
        chk_head("after_flush", 32'h1C00_4000, 4'b0001);

        // reset wins over flush and clears sticky overflow
        rst = 1'b1;
        drive(1, 32'h1C00_5000, 4'hF, 0, 1);
        rst = 1'b0;
        chk_stat("rst_flush", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch queue (ififo) between the fetch stage (PC + I-cache + predecoder) and decode.
- Buffers 4-wide fetch packets and presents the oldest packet to decode, first-word fall-through.
- Generates full_ififo back to the PC stage to throttle fetch.
- Drops all contents on any pipeline flush.

Parameters:
DEPTH, 8, packet entries; power of two, >= 4
SKID, 2, entries reserved for in-flight fetch packets after full_ififo asserts
CNT_W, $clog2(DEPTH)+1, width of occupancy counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  OR of branch/excp/ertn/idle flush; clears queue
push_valid  in  1  fetch packet valid this cycle
push_pc  in  32  PC of slot 0; slot i PC = push_pc + 4*i
push_inst  in  4x32  instruction words, slots 0..3
push_mask  in  4  per-slot valid (truncated after predicted-taken or jump)
push_predict  in  1  packet ends in predicted-taken branch
push_target  in  32  predicted target for push_predict
full_ififo  out  1  to PC: stop fetching
pop_ready  in  1  decode accepts head packet this cycle
out_valid  out  1  head packet present
out_pc  out  4x32  per-slot PCs of head packet
out_inst  out  4x32  head instructions
out_mask  out  4  head slot valids
out_predict  out  1  head predict flag
out_target  out  32  head predicted target
count  out  CNT_W  current occupancy, for perf counters
ovf_err  out  1  sticky: push arrived while full

Behaviour:
- State: DEPTH-entry array {pc, inst[4], mask, predict, target}, rd_ptr/wr_ptr ($clog2(DEPTH) bits, natural wrap), count register.
- Reset (rst=1 at posedge): rd_ptr=wr_ptr=0, count=0, ovf_err=0. out_valid=0, full_ififo=0 (0 < DEPTH-SKID). Array contents not reset.
- out_valid = (count != 0), combinational from registers.
- out_* driven from entry[rd_ptr], combinational (FWFT). out_pc[i] = stored pc + 4*i, 32-bit wrap.
- pop fire = out_valid & pop_ready. On fire: rd_ptr+1.
- push accept = push_valid & (push_mask != 0) & (count < DEPTH | pop fire).
  - On accept: write entry[wr_ptr], wr_ptr+1.
  - push_mask==0 packets are discarded silently.
- Simultaneous push+pop: count unchanged. Legal at count==DEPTH (write into slot freed this cycle) and at count==0 (pushed packet visible next cycle, no bypass).
- Overflow: push_valid & mask!=0 & count==DEPTH & no pop → packet dropped; ovf_err set, sticky until rst. Unreachable if SKID is sized correctly; bench flags it.
- full_ififo = (count >= DEPTH-SKID), combinational from count register. Latency: push that reaches the threshold raises full_ififo the next cycle.
- flush (priority over push/pop): next cycle rd_ptr=wr_ptr=0, count=0. Same-cycle push is discarded; same-cycle pop is not counted, and decode must also honour flush. ovf_err unaffected.
- rst has priority over flush.
- Latency: push at cycle N → out_valid at N+1 (if queue was empty).

Decomposition:
- Shared package (defs): fetch_pkt_t struct {pc, inst[4], mask, predict, target}; FETCH_WIDTH=4 constant; IFQ_DEPTH default.
- One sub-module: ifq_ptr_ctrl (pointers, count, full/valid, overflow flag).
- Storage array and out_pc adders stay in top.

Test Plan:
- Reset then push pc=0x1C000000, mask=4'b1111 → next cycle out_valid=1, out_pc={0x1C000000,04,08,0C}; pop → out_valid=0, count=0.
- Push 6 packets, no pops (DEPTH=8, SKID=2) → full_ififo=1 the cycle after 6th push. Push 2 more → count=8, ovf_err=0. 9th push → dropped, ovf_err=1.
- Count=8, push+pop same cycle → count stays 8; head advances; new packet at tail; order preserved.
- Push 10 packets with interleaved pops across pointer wrap → output order equals push order; pc/inst/mask/predict/target bit-exact.
- Count=5, flush with simultaneous push and pop → next cycle count=0, out_valid=0, full_ififo=0; pushed packet never appears.
- Push with mask=4'b0000 → count unchanged. Push mask=4'b0011, predict=1, target=0x1C000100 → out_mask=0011, out_target=0x1C000100.
